// File: rtl/morse_rx_decoder.sv
// morse_rx_decoder
// Decodes the time-expanded Morse line from the TX stage. The line is sampled
// once per half-second tick (any change of iHalfSec). Mark runs of DOT_TICKS
// or DASH_TICKS become Dot/Dash, a space run of CHAR_GAP_TICKS ends the
// character, and the A-Z letter index (A=0) is shifted into a 7-slot buffer.
//
// Ports:
//   iCLK, iRST    clock, asynchronous active-high reset
//   iEnable       decoder enable; when low, ticks are ignored and the
//                 assembler is held idle (buffer/char/error retained)
//   iLine         Morse line, 1 = mark
//   iHalfSec      free-running half-second counter; a change is one tick
//   iClear        synchronous clear of buffer, error and assembler
//   oChar         last decoded letter index
//   oCharValid    one-clock pulse when oChar/oDisplayData update
//   oDisplayData  7 x 5-bit slots, newest in [4:0], oldest in [34:30]
//   oError        sticky decode error, cleared by a good character or iClear
//   oBusy         high while the decoder is not idle
//   oState        current FSM state (debug)
module morse_rx_decoder #(
    parameter int DOT_TICKS      = 1,
    parameter int DASH_TICKS     = 3,
    parameter int CHAR_GAP_TICKS = 3,
    parameter int EMPTY_CODE     = 31
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEnable,
    input  logic        iLine,
    input  logic [3:0]  iHalfSec,
    input  logic        iClear,
    output logic [4:0]  oChar,
    output logic        oCharValid,
    output logic [34:0] oDisplayData,
    output logic        oError,
    output logic        oBusy,
    output logic [1:0]  oState
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, RESYNC} state_t;

    localparam logic [2:0]  DOT_W   = 3'(DOT_TICKS);
    localparam logic [2:0]  DASH_W  = 3'(DASH_TICKS);
    localparam logic [2:0]  GAP_W   = 3'(CHAR_GAP_TICKS);
    localparam logic [34:0] EMPTY_W = {7{5'(EMPTY_CODE)}};

    state_t      state, state_n;
    logic [2:0]  mark_cnt, mark_cnt_n;
    logic [2:0]  space_cnt, space_cnt_n;
    logic [3:0]  sym_bits, sym_bits_n;
    logic [2:0]  sym_len, sym_len_n;
    logic [3:0]  prev_half_sec;
    logic [4:0]  char_q, char_n;
    logic        char_valid_q, char_valid_n;
    logic [34:0] display_q, display_n;
    logic        error_q, error_n;
    logic        tick;
    logic [5:0]  look;

    // Returns {hit, index}. Symbols are LSB-first, Dash = 1; unused upper
    // bits of sym_bits are always zero because the assembler clears them.
    function automatic logic [5:0] lookup(input logic [2:0] len, input logic [3:0] bits);
        case ({len, bits})
            {3'd2, 4'b0010}: lookup = {1'b1, 5'd0};   // A .-
            {3'd4, 4'b0001}: lookup = {1'b1, 5'd1};   // B -...
            {3'd4, 4'b0101}: lookup = {1'b1, 5'd2};   // C -.-.
            {3'd3, 4'b0001}: lookup = {1'b1, 5'd3};   // D -..
            {3'd1, 4'b0000}: lookup = {1'b1, 5'd4};   // E .
            {3'd4, 4'b0100}: lookup = {1'b1, 5'd5};   // F ..-.
            {3'd3, 4'b0011}: lookup = {1'b1, 5'd6};   // G --.
            {3'd4, 4'b0000}: lookup = {1'b1, 5'd7};   // H ....
            {3'd2, 4'b0000}: lookup = {1'b1, 5'd8};   // I ..
            {3'd4, 4'b1110}: lookup = {1'b1, 5'd9};   // J .---
            {3'd3, 4'b0101}: lookup = {1'b1, 5'd10};  // K -.-
            {3'd4, 4'b0010}: lookup = {1'b1, 5'd11};  // L .-..
            {3'd2, 4'b0011}: lookup = {1'b1, 5'd12};  // M --
            {3'd2, 4'b0001}: lookup = {1'b1, 5'd13};  // N -.
            {3'd3, 4'b0111}: lookup = {1'b1, 5'd14};  // O ---
            {3'd4, 4'b0110}: lookup = {1'b1, 5'd15};  // P .--.
            {3'd4, 4'b1011}: lookup = {1'b1, 5'd16};  // Q --.-
            {3'd3, 4'b0010}: lookup = {1'b1, 5'd17};  // R .-.
            {3'd3, 4'b0000}: lookup = {1'b1, 5'd18};  // S ...
            {3'd1, 4'b0001}: lookup = {1'b1, 5'd19};  // T -
            {3'd3, 4'b0100}: lookup = {1'b1, 5'd20};  // U ..-
            {3'd4, 4'b1000}: lookup = {1'b1, 5'd21};  // V ...-
            {3'd3, 4'b0110}: lookup = {1'b1, 5'd22};  // W .--
            {3'd4, 4'b1001}: lookup = {1'b1, 5'd23};  // X -..-
            {3'd4, 4'b1101}: lookup = {1'b1, 5'd24};  // Y -.--
            {3'd4, 4'b0011}: lookup = {1'b1, 5'd25};  // Z --..
            default:         lookup = 6'd0;
        endcase
    endfunction

    assign tick = (iHalfSec != prev_half_sec);
    assign look = lookup(sym_len, sym_bits);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state         <= IDLE;
            mark_cnt      <= 3'd0;
            space_cnt     <= 3'd0;
            sym_bits      <= 4'd0;
            sym_len       <= 3'd0;
            prev_half_sec <= 4'd0;
            char_q        <= 5'd0;
            char_valid_q  <= 1'b0;
            display_q     <= EMPTY_W;
            error_q       <= 1'b0;
        end else begin
            state         <= state_n;
            mark_cnt      <= mark_cnt_n;
            space_cnt     <= space_cnt_n;
            sym_bits      <= sym_bits_n;
            sym_len       <= sym_len_n;
            prev_half_sec <= iHalfSec;
            char_q        <= char_n;
            char_valid_q  <= char_valid_n;
            display_q     <= display_n;
            error_q       <= error_n;
        end
    end

    always_comb begin
        state_n      = state;
        mark_cnt_n   = mark_cnt;
        space_cnt_n  = space_cnt;
        sym_bits_n   = sym_bits;
        sym_len_n    = sym_len;
        char_n       = char_q;
        char_valid_n = 1'b0;
        display_n    = display_q;
        error_n      = error_q;

        if (iClear) begin
            // Wins over a completion on the same tick: that character is dropped.
            state_n     = IDLE;
            mark_cnt_n  = 3'd0;
            space_cnt_n = 3'd0;
            sym_bits_n  = 4'd0;
            sym_len_n   = 3'd0;
            display_n   = EMPTY_W;
            error_n     = 1'b0;
        end else if (!iEnable) begin
            state_n     = IDLE;
            mark_cnt_n  = 3'd0;
            space_cnt_n = 3'd0;
            sym_bits_n  = 4'd0;
            sym_len_n   = 3'd0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (iLine) begin
                        state_n    = MARK;
                        mark_cnt_n = 3'd1;
                    end
                end
                MARK: begin
                    if (iLine) begin
                        if (mark_cnt != 3'd7) mark_cnt_n = mark_cnt + 3'd1;
                    end else if ((mark_cnt == DOT_W || mark_cnt == DASH_W) && sym_len != 3'd4) begin
                        sym_bits_n[sym_len[1:0]] = (mark_cnt == DASH_W);
                        sym_len_n   = sym_len + 3'd1;
                        state_n     = SPACE;
                        space_cnt_n = 3'd1;
                        mark_cnt_n  = 3'd0;
                    end else begin
                        error_n     = 1'b1;
                        sym_bits_n  = 4'd0;
                        sym_len_n   = 3'd0;
                        state_n     = RESYNC;
                        space_cnt_n = 3'd0;
                        mark_cnt_n  = 3'd0;
                    end
                end
                SPACE: begin
                    if (iLine) begin
                        // Only reachable with space_cnt below the gap length.
                        state_n    = MARK;
                        mark_cnt_n = 3'd1;
                    end else if (space_cnt + 3'd1 == GAP_W) begin
                        if (look[5]) begin
                            char_n       = look[4:0];
                            display_n    = {display_q[29:0], look[4:0]};
                            char_valid_n = 1'b1;
                            error_n      = 1'b0;
                        end else begin
                            error_n = 1'b1;
                        end
                        // A full gap has already been seen, so a miss can
                        // restart straight from IDLE.
                        sym_bits_n  = 4'd0;
                        sym_len_n   = 3'd0;
                        state_n     = IDLE;
                        space_cnt_n = 3'd0;
                    end else begin
                        space_cnt_n = space_cnt + 3'd1;
                    end
                end
                RESYNC: begin
                    if (iLine) begin
                        space_cnt_n = 3'd0;
                    end else if (space_cnt + 3'd1 == GAP_W) begin
                        state_n     = IDLE;
                        space_cnt_n = 3'd0;
                    end else begin
                        space_cnt_n = space_cnt + 3'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign oChar        = char_q;
    assign oCharValid   = char_valid_q;
    assign oDisplayData = display_q;
    assign oError       = error_q;
    assign oBusy        = (state != IDLE);
    assign oState       = state;

endmodule
